// File: rtl/insn_assembler_if.sv
// Byte-stream, decoder-query and assembled-instruction signals for insn_assembler.
// The master side feeds bytes, answers decoder queries and consumes instructions; the slave is the assembler.
interface insn_assembler_if #(
    parameter int IMM_MAX_BYTES = 2,
    parameter int ADDR_W        = 24
);
    logic                       in_valid;
    logic                       in_ready;
    logic [7:0]                 in_data;
    logic                       flush;
    logic [ADDR_W-1:0]          flush_addr;
    logic [7:0]                 dec_opcode;
    logic [7:0]                 dec_opext;
    logic                       dec_need_opext;
    logic [1:0]                 dec_imm_len;
    logic                       out_valid;
    logic                       out_ready;
    logic [7:0]                 out_opcode;
    logic [7:0]                 out_opext;
    logic [8*IMM_MAX_BYTES-1:0] out_imm;
    logic [2:0]                 out_len;
    logic [ADDR_W-1:0]          out_addr;
    logic                       out_err;

    modport slave (
        input  in_valid, in_data, flush, flush_addr, dec_need_opext, dec_imm_len, out_ready,
        output in_ready, dec_opcode, dec_opext, out_valid, out_opcode, out_opext, out_imm,
               out_len, out_addr, out_err
    );

    modport master (
        output in_valid, in_data, flush, flush_addr, dec_need_opext, dec_imm_len, out_ready,
        input  in_ready, dec_opcode, dec_opext, out_valid, out_opcode, out_opext, out_imm,
               out_len, out_addr, out_err
    );
endinterface

// File: rtl/insn_assembler.sv
// Assembles variable-length instructions (opcode, optional opext, 0..IMM_MAX_BYTES immediates)
// from a byte stream, consulting an external combinational decoder for the layout.
module insn_assembler #(
    parameter int IMM_MAX_BYTES = 2,
    parameter int ADDR_W        = 24
) (
    input  logic              clk,
    input  logic              reset,
    insn_assembler_if.slave   bus
);
    localparam logic [1:0] S_OPCODE = 2'd0;
    localparam logic [1:0] S_OPEXT  = 2'd1;
    localparam logic [1:0] S_IMM    = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int         IMM_W     = 8 * IMM_MAX_BYTES;
    localparam logic [2:0] IMM_MAX_L = 3'(IMM_MAX_BYTES);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic [7:0]        opcode_r;
    logic [7:0]        opext_r;
    logic [IMM_W-1:0]  imm_r;
    logic [2:0]        len_r;
    logic [1:0]        rem_r;
    logic [1:0]        imm_idx_r;
    logic              err_r;
    logic              in_ready_s;
    logic              accept_s;
    logic [7:0]        dec_opcode_s;
    logic [7:0]        dec_opext_s;
    logic [1:0]        eval_state_s;
    logic              eval_err_s;

    // Where the decoder's immediate count sends us: {next_state, err}.
    function automatic logic [2:0] eval_len(input logic [1:0] imm_len);
        logic [2:0] res;
        if (imm_len == 2'd0) begin
            res = {S_DONE, 1'b0};
        end else if ({1'b0, imm_len} > IMM_MAX_L) begin
            res = {S_DONE, 1'b1};
        end else begin
            res = {S_IMM, 1'b0};
        end
        return res;
    endfunction

    // Byte acceptance: blocked while an instruction waits for pickup or a flush is in progress.
    always_comb begin
        in_ready_s = 1'b0;
        if (!bus.flush && (state_r != S_DONE)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = bus.in_valid & in_ready_s;
    end

    // Decoder query bytes: live input while that byte is being accepted, captured value afterwards.
    always_comb begin
        dec_opcode_s = opcode_r;
        dec_opext_s  = opext_r;
        if (state_r == S_OPCODE) begin
            dec_opcode_s = bus.in_data;
        end else begin
            dec_opcode_s = opcode_r;
        end
        if (state_r == S_OPEXT) begin
            dec_opext_s = bus.in_data;
        end else begin
            dec_opext_s = opext_r;
        end
    end

    // Next-state selection; flush and reset are applied with priority in the register block.
    always_comb begin
        state_nxt_s                = state_r;
        {eval_state_s, eval_err_s} = eval_len(bus.dec_imm_len);
        case (state_r)
            S_OPCODE: begin
                if (accept_s) begin
                    if (bus.dec_need_opext) begin
                        state_nxt_s = S_OPEXT;
                    end else begin
                        state_nxt_s = eval_state_s;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_OPEXT: begin
                if (accept_s) begin
                    state_nxt_s = eval_state_s;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_IMM: begin
                if (accept_s && (rem_r == 2'd1)) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = S_OPCODE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = S_OPCODE;
            end
        endcase
    end

    // State, address counter and captured instruction fields.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            state_r    <= S_OPCODE;
            addr_r     <= reset ? {ADDR_W{1'b0}} : bus.flush_addr;
            out_addr_r <= {ADDR_W{1'b0}};
            opcode_r   <= 8'd0;
            opext_r    <= 8'd0;
            imm_r      <= {IMM_W{1'b0}};
            len_r      <= 3'd0;
            rem_r      <= 2'd0;
            imm_idx_r  <= 2'd0;
            err_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                addr_r <= addr_r + ADDR_W'(1);
            end
            case (state_r)
                S_OPCODE: begin
                    if (accept_s) begin
                        // A new instruction starts from a clean slate so unused fields read as zero.
                        opcode_r   <= bus.in_data;
                        opext_r    <= 8'd0;
                        imm_r      <= {IMM_W{1'b0}};
                        len_r      <= 3'd1;
                        out_addr_r <= addr_r;
                        imm_idx_r  <= 2'd0;
                        rem_r      <= bus.dec_need_opext ? 2'd0 : bus.dec_imm_len;
                        err_r      <= !bus.dec_need_opext && eval_err_s;
                    end
                end
                S_OPEXT: begin
                    if (accept_s) begin
                        opext_r <= bus.in_data;
                        len_r   <= len_r + 3'd1;
                        rem_r   <= bus.dec_imm_len;
                        err_r   <= eval_err_s;
                    end
                end
                S_IMM: begin
                    if (accept_s) begin
                        for (int b = 0; b < IMM_MAX_BYTES; b++) begin
                            if (imm_idx_r == 2'(b)) begin
                                imm_r[b*8 +: 8] <= bus.in_data;
                            end
                        end
                        imm_idx_r <= imm_idx_r + 2'd1;
                        rem_r     <= rem_r - 2'd1;
                        len_r     <= len_r + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.dec_opcode = dec_opcode_s;
    assign bus.dec_opext  = dec_opext_s;
    assign bus.out_valid  = (state_r == S_DONE);
    assign bus.out_opcode = opcode_r;
    assign bus.out_opext  = opext_r;
    assign bus.out_imm    = imm_r;
    assign bus.out_len    = len_r;
    assign bus.out_addr   = out_addr_r;
    assign bus.out_err    = err_r;
endmodule

// File: tb/tb_insn_assembler.sv
// Randomized bench for insn_assembler: a byte-level instruction model predicts every output,
// plus directed scenarios for address wrap, flush, stall, oversize immediates and reset.
module tb_insn_assembler;
    localparam int IMM_MAX_BYTES = 2;
    localparam int ADDR_W        = 24;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  ext;
        logic [15:0] imm;
    } req_t;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  ext;
        logic [15:0] imm;
        logic [2:0]  len;
        logic [23:0] addr;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    insn_assembler_if #(.IMM_MAX_BYTES(IMM_MAX_BYTES), .ADDR_W(ADDR_W)) bus ();

    insn_assembler #(.IMM_MAX_BYTES(IMM_MAX_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Bench decoder: opcodes 0xC0..0xFF take an opext; immediate count = op[1:0] ^ opext[1:0].
    always_comb begin
        logic need_v;
        need_v             = (bus.dec_opcode[7:6] == 2'b11);
        bus.dec_need_opext = need_v;
        bus.dec_imm_len    = bus.dec_opcode[1:0] ^ (need_v ? bus.dec_opext[1:0] : 2'b00);
    end

    int          total = 0;
    int          bad   = 0;
    int          p_valid = 100;
    int          p_ready = 100;
    bit          rand_mode = 1'b0;
    req_t        dq[$];
    logic [7:0]  cur_bytes[$];
    exp_t        exp_r;
    bit          pending = 1'b0;
    bit          chk_zero = 1'b0;
    int          consumed = 0;
    int          n_out = 0;
    logic [23:0] maddr = 24'd0;
    logic [23:0] last_addr;
    logic [2:0]  last_len;
    logic        last_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Build the byte sequence and expected result of one instruction from the layout rules.
    task automatic load(input req_t r);
        logic       need;
        logic [1:0] n;
        need        = (r.op[7:6] == 2'b11);
        n           = r.op[1:0] ^ (need ? r.ext[1:0] : 2'b00);
        exp_r.op    = r.op;
        exp_r.ext   = need ? r.ext : 8'd0;
        exp_r.err   = (n > 2'd2);
        exp_r.imm   = 16'd0;
        exp_r.len   = 3'd1 + (need ? 3'd1 : 3'd0) + (exp_r.err ? 3'd0 : {1'b0, n});
        exp_r.addr  = 24'd0;
        cur_bytes.delete();
        cur_bytes.push_back(r.op);
        if (need) cur_bytes.push_back(r.ext);
        if (!exp_r.err) begin
            for (int i = 0; i < int'(n); i++) begin
                cur_bytes.push_back(r.imm[8*i +: 8]);
                exp_r.imm[8*i +: 8] = r.imm[8*i +: 8];
            end
        end
        consumed = 0;
    endtask

    // One clock: drive inputs at the falling edge, check at +1, advance the model for the next rising edge.
    task automatic step(input bit fl, input logic [23:0] fa);
        req_t rr;
        @(negedge clk);
        if (!pending && cur_bytes.size() == 0) begin
            if (dq.size() > 0) begin
                load(dq.pop_front());
            end else if (rand_mode) begin
                rr.op  = 8'($urandom);
                rr.ext = 8'($urandom);
                rr.imm = 16'($urandom);
                load(rr);
            end
        end
        bus.flush      = fl;
        bus.flush_addr = fa;
        bus.in_valid   = ((cur_bytes.size() > 0) || pending) && ($urandom_range(99) < p_valid);
        bus.in_data    = (cur_bytes.size() > 0) ? cur_bytes[0] : 8'($urandom);
        bus.out_ready  = ($urandom_range(99) < p_ready);
        #1;
        if (chk_zero) begin
            check_val("clr_opcode", bus.out_opcode, 0);
            check_val("clr_opext", bus.out_opext, 0);
            check_val("clr_imm", bus.out_imm, 0);
            check_val("clr_len", bus.out_len, 0);
            check_val("clr_addr", bus.out_addr, 0);
            check_val("clr_err", bus.out_err, 0);
            chk_zero = 1'b0;
        end
        check_val("in_ready", bus.in_ready, !pending && !fl);
        check_val("out_valid", bus.out_valid, pending);
        if (pending) begin
            check_val("out_opcode", bus.out_opcode, exp_r.op);
            check_val("out_opext", bus.out_opext, exp_r.ext);
            check_val("out_imm", bus.out_imm, exp_r.imm);
            check_val("out_len", bus.out_len, exp_r.len);
            check_val("out_addr", bus.out_addr, exp_r.addr);
            check_val("out_err", bus.out_err, exp_r.err);
        end
        if (fl) begin
            cur_bytes.delete();
            pending  = 1'b0;
            consumed = 0;
            maddr    = fa;
            chk_zero = 1'b1;
        end else if (pending) begin
            if (bus.out_ready) begin
                pending   = 1'b0;
                n_out++;
                last_addr = bus.out_addr;
                last_len  = bus.out_len;
                last_err  = bus.out_err;
            end
        end else if (bus.in_valid) begin
            if (consumed == 0) exp_r.addr = maddr;
            consumed++;
            maddr = maddr + 24'd1;
            void'(cur_bytes.pop_front());
            if (cur_bytes.size() == 0) pending = 1'b1;
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step(1'b0, 24'd0);
            done = !pending && (cur_bytes.size() == 0) && (dq.size() == 0);
        end
        if (!done) check_val("drain_timeout", 0, 1);
    endtask

    task automatic wait_consumed(input int n);
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            step(1'b0, 24'd0);
            done = (consumed >= n);
        end
        if (!done) check_val("consume_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        pending  = 1'b0;
        cur_bytes.delete();
        consumed = 0;
        maddr    = 24'd0;
        chk_zero = 1'b1;
    endtask

    task automatic push(input logic [7:0] op, input logic [7:0] ext, input logic [15:0] imm);
        req_t r;
        r.op  = op;
        r.ext = ext;
        r.imm = imm;
        dq.push_back(r);
    endtask

    initial begin
        int n0;
        reset          = 1'b1;
        bus.flush      = 1'b0;
        bus.flush_addr = 24'd0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'd0;
        bus.out_ready  = 1'b0;
        do_reset();

        // Single-byte instruction right after reset.
        push(8'h00, 8'h00, 16'h0000);
        drain();
        check_val("first_addr", last_addr, 24'h000000);
        check_val("first_len", last_len, 1);

        // Opcode + opext + two immediates, then the next instruction's address.
        do_reset();
        push(8'hCE, 8'h44, 16'h1234);
        push(8'h00, 8'h00, 16'h0000);
        drain();
        check_val("after4_addr", last_addr, 24'h000004);

        // Output stall with bytes on offer: nothing consumed, outputs held.
        p_ready = 0;
        push(8'h01, 8'h00, 16'h00AB);
        wait_consumed(2);
        repeat (5) step(1'b0, 24'd0);
        p_ready = 100;
        push(8'h00, 8'h00, 16'h0000);
        drain();
        check_val("stall_addr", last_addr, 24'h000007);

        // Flush after the opcode of a 3-byte instruction.
        n0 = n_out;
        push(8'h02, 8'h00, 16'h5566);
        wait_consumed(1);
        step(1'b1, 24'h00FFFF);
        push(8'h00, 8'h00, 16'h0000);
        push(8'h01, 8'h00, 16'h0077);
        drain();
        check_val("flush_nout", n_out - n0, 2);
        check_val("flush_next_addr", last_addr, 24'h010000);

        // Address wrap.
        step(1'b1, 24'hFFFFFF);
        push(8'h01, 8'h00, 16'h0099);
        push(8'h00, 8'h00, 16'h0000);
        drain();
        check_val("wrap_addr", last_addr, 24'h000001);

        // Oversize immediate count: error, no immediates consumed.
        push(8'h03, 8'h00, 16'hFFFF);
        drain();
        check_val("err_flag", last_err, 1);
        check_val("err_len", last_len, 1);
        push(8'h00, 8'h00, 16'h0000);
        drain();
        check_val("post_err_flag", last_err, 0);

        // Reset in the middle of an instruction discards it.
        push(8'hCE, 8'h44, 16'h1234);
        wait_consumed(2);
        do_reset();
        n0 = n_out;
        push(8'h00, 8'h00, 16'h0000);
        drain();
        check_val("rst_nout", n_out - n0, 1);
        check_val("rst_addr", last_addr, 24'h000000);

        // Random traffic with occasional flushes.
        p_valid   = 70;
        p_ready   = 60;
        rand_mode = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(99) < 2, 24'($urandom));
        end
        rand_mode = 1'b0;
        p_valid   = 100;
        p_ready   = 100;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
